piano_melody_sequencer: RTL and testbench
=========================================

// Module: piano_melody_sequencer
// PURPOSE
//  Autoplay controller for the piano tone path. Steps through a small note RAM, holding each
//  note for a programmed number of beat ticks. Drives a one-hot note select that replaces the
//  8 note switches at the tone mux (bit0=C4 ... bit7=C5). Software/buttons start, stop and load it.
// PARAMETERS
//  CLK_HZ      100_000_000  system clock frequency
//  BEAT_HZ     8            beat tick rate; TICK_DIV = CLK_HZ/BEAT_HZ cycles per tick (>=2)
//  MELODY_LEN  16           note RAM depth (power of 2); AW = $clog2(MELODY_LEN)
//  GAP_TICKS   1            silent ticks inserted after every entry (0 = legato, no gap)
// PORTS
//  CLK        in   1   system clock
//  RESET      in   1   asynchronous, active-high reset
//  START      in   1   pulse; begin playback at entry 0 (accepted in IDLE only)
//  STOP       in   1   pulse; abort playback, silence output
//  LOAD_WE    in   1   note RAM write strobe (accepted in IDLE only)
//  LOAD_ADDR  in   AW  RAM write address
//  LOAD_DATA  in   8   entry {note[7:4], dur[3:0]}
//  NOTE_SEL   out  8   one-hot note select to tone mux; 0 = silence
//  STEP_IDX   out  AW  index of entry currently sounding
//  BUSY       out  1   high in every state except IDLE
//  DONE       out  1   one-cycle pulse on normal melody completion
// BEHAVIOUR
//  - Reset: state IDLE, NOTE_SEL=0, STEP_IDX=0, BUSY=0, DONE=0, prescaler=0. RAM not cleared;
//    RAM initial contents = DEFAULT_MELODY.
//  - Entry codes: note 0..7 = C4..C5 (NOTE_SEL = 1<<note); 8..14 = rest (NOTE_SEL=0);
//    15 = END marker. dur=0 is treated as 1.
//  - FSM IDLE -> FETCH -> PLAY -> GAP -> FETCH ... -> DONE -> IDLE.
//    IDLE : START => addr=0, FETCH. LOAD_WE writes RAM. Writes in other states are dropped.
//    FETCH: 1 cycle (registered RAM read). END => DONE; else load dur counter, PLAY.
//    PLAY : NOTE_SEL valid from the first PLAY cycle, which is 2 cycles after START is sampled.
//           Prescaler restarts at PLAY entry. The note lasts exactly dur*TICK_DIV cycles.
//    GAP  : NOTE_SEL=0 for GAP_TICKS*TICK_DIV cycles (skipped if 0). Then addr+1 -> FETCH.
//           If addr==MELODY_LEN-1, go to DONE instead (end of RAM acts as END).
//    DONE : DONE=1 for one cycle, NOTE_SEL=0 -> IDLE.
//  - STOP in any non-IDLE state: IDLE next cycle, NOTE_SEL=0, no DONE pulse. STOP and START
//    in the same cycle: STOP wins. START while BUSY is ignored.
//  - Prescaler runs only in PLAY/GAP. Tick = cycle where count == TICK_DIV-1, then wraps to 0.
//  - STEP_IDX tracks addr; it holds its last value in IDLE until the next START.
//  - RESET mid-note: NOTE_SEL drops asynchronously to 0.
// CONFIGURATION
//  MELODY_LOOP_EN defined: adds input LOOP (1 bit, listed after STOP). On END or end of RAM
//    with LOOP=1, go to FETCH at addr 0 with no DONE pulse and no extra cycles beyond the
//    normal FETCH. LOOP=0 behaves as the undefined case.
//  MELODY_LOOP_EN undefined: LOOP port and logic absent; playback always ends in DONE.
// STRUCTURE
//  - Package piano_pkg: note code localparams (NOTE_C4..NOTE_C5, NOTE_REST=8, NOTE_END=15),
//    state enum encoding, DEFAULT_MELODY array (C major scale then END).
//  - Sub-module piano_beat_timer: prescaler with clear input and one-cycle TICK output;
//    parameter TICK_DIV.
//  - Note RAM is inferred inside this module (sync write, registered read).
// TESTING (sim params CLK_HZ=100, BEAT_HZ=10 -> TICK_DIV=10; GAP_TICKS=1)
//  - Reset: hold RESET -> NOTE_SEL=0, BUSY=0, DONE=0. Release, idle 50 cycles -> outputs
//    unchanged.
//  - Load {0x02,0x41,0xF0} at 0..2, START -> NOTE_SEL=0x01 for 20 cycles, 0 for 10,
//    0x10 for 10, 0 for 10, then DONE pulses once and BUSY falls the cycle after.
//  - STOP 5 cycles into entry 0 -> NOTE_SEL=0 and BUSY=0 the next cycle, no DONE.
//    START+STOP in the same cycle from IDLE -> stays IDLE.
//  - LOAD_WE while BUSY -> RAM unchanged (replay matches). START while BUSY -> no restart.
//  - Rest and dur=0: entry 0x80 -> NOTE_SEL=0 for 10 cycles. No END in RAM -> DONE after
//    entry 15.
//  - MELODY_LOOP_EN with LOOP=1 -> after END, entry 0 replays, no DONE; drop LOOP -> DONE
//    at the next END.

Source files
------------

// File: rtl/piano_pkg.sv
// Purpose : shared note codes, FSM state encoding and the power-up melody for the piano sequencer.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: NOTE_* entry codes, state_t, DEFAULT_MELODY (C major scale then END), note_onehot().
package piano_pkg;

    // Upper nibble of a RAM entry.
    localparam logic [3:0] NOTE_C4   = 4'd0;
    localparam logic [3:0] NOTE_D4   = 4'd1;
    localparam logic [3:0] NOTE_E4   = 4'd2;
    localparam logic [3:0] NOTE_F4   = 4'd3;
    localparam logic [3:0] NOTE_G4   = 4'd4;
    localparam logic [3:0] NOTE_A4   = 4'd5;
    localparam logic [3:0] NOTE_B4   = 4'd6;
    localparam logic [3:0] NOTE_C5   = 4'd7;
    localparam logic [3:0] NOTE_REST = 4'd8;   // 8..14 all decode as rest
    localparam logic [3:0] NOTE_END  = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_PLAY  = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Power-up RAM image, sized for the default 16-entry RAM.
    localparam int DEFAULT_LEN = 16;
    localparam logic [7:0] DEFAULT_MELODY [DEFAULT_LEN] = '{
        {NOTE_C4, 4'd2}, {NOTE_D4, 4'd2}, {NOTE_E4, 4'd2}, {NOTE_F4, 4'd2},
        {NOTE_G4, 4'd2}, {NOTE_A4, 4'd2}, {NOTE_B4, 4'd2}, {NOTE_C5, 4'd2},
        {NOTE_END, 4'd0}, {NOTE_END, 4'd0}, {NOTE_END, 4'd0}, {NOTE_END, 4'd0},
        {NOTE_END, 4'd0}, {NOTE_END, 4'd0}, {NOTE_END, 4'd0}, {NOTE_END, 4'd0}
    };

    // Codes 0..7 select one switch; anything with bit3 set is silent.
    function automatic logic [7:0] note_onehot(input logic [3:0] code);
        return code[3] ? 8'h00 : (8'h01 << code[2:0]);
    endfunction

endpackage

// File: rtl/piano_melody_sequencer_if.sv
// Purpose : control/load/status bundle between a host (master) and the melody sequencer (slave).
// Latency : n/a (wires only).
// Backpressure: none; strobes are single-cycle pulses, LOAD_WE is dropped unless the sequencer is idle.
// Signals : START, STOP, [LOOP when MELODY_LOOP_EN], LOAD_WE/ADDR/DATA host->seq; NOTE_SEL, STEP_IDX, BUSY, DONE seq->host.
interface piano_melody_sequencer_if #(
    parameter int AW = 4
);
    logic          START;
    logic          STOP;
`ifdef MELODY_LOOP_EN
    logic          LOOP;
`endif
    logic          LOAD_WE;
    logic [AW-1:0] LOAD_ADDR;
    logic [7:0]    LOAD_DATA;
    logic [7:0]    NOTE_SEL;
    logic [AW-1:0] STEP_IDX;
    logic          BUSY;
    logic          DONE;

    modport master (
`ifdef MELODY_LOOP_EN
        output LOOP,
`endif
        output START, STOP, LOAD_WE, LOAD_ADDR, LOAD_DATA,
        input  NOTE_SEL, STEP_IDX, BUSY, DONE
    );

    modport slave (
`ifdef MELODY_LOOP_EN
        input  LOOP,
`endif
        input  START, STOP, LOAD_WE, LOAD_ADDR, LOAD_DATA,
        output NOTE_SEL, STEP_IDX, BUSY, DONE
    );
endinterface

// File: rtl/piano_beat_timer.sv
// Purpose : beat prescaler; counts 0..TICK_DIV-1 while run is high, restarts from 0 on clear.
// Latency : tick is asserted combinationally in the cycle where the count reaches TICK_DIV-1.
// Backpressure: none; run gates counting, clear has priority over run.
// Ports   : CLK, RESET (async, high), clear, run in; tick out (one cycle per TICK_DIV running cycles).
module piano_beat_timer #(
    parameter int TICK_DIV = 10
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clear,
    input  logic run,
    output logic tick
);
    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] count;

    assign tick = run && (count == CW'(TICK_DIV - 1));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run) begin
            count <= tick ? '0 : count + CW'(1);
        end
    end
endmodule

// File: rtl/piano_melody_sequencer.sv
// Purpose : autoplay controller; walks the note RAM and drives a one-hot note select for the tone mux.
// Latency : NOTE_SEL valid 2 cycles after START is sampled; each note lasts dur*TICK_DIV cycles.
// Backpressure: none; START ignored while BUSY, LOAD_WE dropped while BUSY, STOP aborts at once.
// Ports   : CLK, RESET (async, high), bus (slave modport). MELODY_LOOP_EN adds bus.LOOP to replay from entry 0.
module piano_melody_sequencer
    import piano_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BEAT_HZ    = 8,
    parameter int MELODY_LEN = 16,
    parameter int GAP_TICKS  = 1    // up to 255
) (
    input  logic                     CLK,
    input  logic                     RESET,
    piano_melody_sequencer_if.slave  bus
);
    localparam int TICK_DIV = CLK_HZ / BEAT_HZ;
    localparam int AW       = $clog2(MELODY_LEN);

    state_t        state;
    logic [AW-1:0] addr;
    logic [7:0]    ticks_left;
    logic [7:0]    note_sel_q;
    logic          busy_q;
    logic          done_q;

    logic [7:0]    ram [MELODY_LEN] = DEFAULT_MELODY;
    logic [7:0]    rd_data;
    logic [AW-1:0] rd_addr;
    logic          tick;
    logic          loop_en;

`ifdef MELODY_LOOP_EN
    assign loop_en = bus.LOOP;
`else
    assign loop_en = 1'b0;
`endif

    piano_beat_timer #(.TICK_DIV(TICK_DIV)) u_timer (
        .CLK   (CLK),
        .RESET (RESET),
        .clear (state == ST_FETCH),
        .run   ((state == ST_PLAY) || (state == ST_GAP)),
        .tick  (tick)
    );

    // The read is issued one cycle ahead so rd_data is ready during FETCH.
    // Every path into FETCH lands on either entry 0 (START, loop) or addr+1
    // (advance, which wraps to 0 on the last entry), so this covers them all.
    assign rd_addr = ((state == ST_PLAY) || (state == ST_GAP)) ? addr + AW'(1) : '0;

    always_ff @(posedge CLK) begin
        if (bus.LOAD_WE && (state == ST_IDLE)) begin
            ram[bus.LOAD_ADDR] <= bus.LOAD_DATA;
        end
        rd_data <= ram[rd_addr];
    end

    logic [3:0] rd_note;
    logic [3:0] rd_dur;
    logic       last_entry;

    assign rd_note    = rd_data[7:4];
    assign rd_dur     = (rd_data[3:0] == 4'd0) ? 4'd1 : rd_data[3:0];
    assign last_entry = (addr == AW'(MELODY_LEN - 1));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= ST_IDLE;
            addr       <= '0;
            ticks_left <= '0;
            note_sel_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.STOP && (state != ST_IDLE)) begin
                state      <= ST_IDLE;
                note_sel_q <= '0;
                busy_q     <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.START && !bus.STOP) begin
                            addr   <= '0;
                            busy_q <= 1'b1;
                            state  <= ST_FETCH;
                        end
                    end
                    ST_FETCH: begin
                        if (rd_note == NOTE_END) begin
                            if (loop_en) begin
                                addr  <= '0;
                                state <= ST_FETCH;
                            end else begin
                                done_q <= 1'b1;
                                state  <= ST_DONE;
                            end
                        end else begin
                            ticks_left <= {4'd0, rd_dur};
                            note_sel_q <= note_onehot(rd_note);
                            state      <= ST_PLAY;
                        end
                    end
                    ST_PLAY: begin
                        if (tick) begin
                            if (ticks_left == 8'd1) begin
                                note_sel_q <= '0;
                                if (GAP_TICKS > 0) begin
                                    ticks_left <= 8'(GAP_TICKS);
                                    state      <= ST_GAP;
                                end else if (last_entry && !loop_en) begin
                                    done_q <= 1'b1;
                                    state  <= ST_DONE;
                                end else begin
                                    addr  <= addr + AW'(1);
                                    state <= ST_FETCH;
                                end
                            end else begin
                                ticks_left <= ticks_left - 8'd1;
                            end
                        end
                    end
                    ST_GAP: begin
                        if (tick) begin
                            if (ticks_left == 8'd1) begin
                                if (last_entry && !loop_en) begin
                                    done_q <= 1'b1;
                                    state  <= ST_DONE;
                                end else begin
                                    addr  <= addr + AW'(1);
                                    state <= ST_FETCH;
                                end
                            end else begin
                                ticks_left <= ticks_left - 8'd1;
                            end
                        end
                    end
                    ST_DONE: begin
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.NOTE_SEL = note_sel_q;
    assign bus.STEP_IDX = addr;
    assign bus.BUSY     = busy_q;
    assign bus.DONE     = done_q;
endmodule

// File: tb/tb_piano_melody_sequencer.sv
// Purpose : directed self-checking bench for piano_melody_sequencer (TICK_DIV=10, GAP_TICKS=1).
// Latency : outputs sampled 1 time unit after each rising CLK edge.
// Backpressure: n/a. Define MELODY_LOOP_EN to also exercise the LOOP input.
module tb_piano_melody_sequencer;
    logic CLK;
    logic RESET;
    int   checks;
    int   errors;

    piano_melody_sequencer_if #(.AW(4)) bus ();

    piano_melody_sequencer #(
        .CLK_HZ     (100),
        .BEAT_HZ    (10),
        .MELODY_LEN (16),
        .GAP_TICKS  (1)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [13:0] obs, input logic [13:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed={sel,idx,busy,done}=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance n cycles, checking all outputs after each edge.
    task automatic run_expect(input int n, input logic [7:0] sel, input logic [3:0] idx,
                              input logic busy, input logic done, input string tag);
        for (int i = 0; i < n; i++) begin
            step();
            chk(tag, {bus.NOTE_SEL, bus.STEP_IDX, bus.BUSY, bus.DONE}, {sel, idx, busy, done});
        end
    endtask

    task automatic load(input logic [3:0] a, input logic [7:0] d);
        bus.LOAD_WE   = 1'b1;
        bus.LOAD_ADDR = a;
        bus.LOAD_DATA = d;
        step();
        bus.LOAD_WE   = 1'b0;
    endtask

    // Melody {0x02,0x41,0xF0} from the start of the gap after entry 0 through to IDLE.
    task automatic abc_tail();
        run_expect(10, 8'h00, 4'd0, 1'b1, 1'b0, "gap0");
        run_expect(1,  8'h00, 4'd1, 1'b1, 1'b0, "fetch1");
        run_expect(10, 8'h10, 4'd1, 1'b1, 1'b0, "note1");
        run_expect(10, 8'h00, 4'd1, 1'b1, 1'b0, "gap1");
        run_expect(1,  8'h00, 4'd2, 1'b1, 1'b0, "fetch_end");
        run_expect(1,  8'h00, 4'd2, 1'b1, 1'b1, "done_pulse");
        run_expect(3,  8'h00, 4'd2, 1'b0, 1'b0, "idle_after");
    endtask

    task automatic abc_full();
        bus.START = 1'b1;
        run_expect(1,  8'h00, 4'd0, 1'b1, 1'b0, "fetch0");
        bus.START = 1'b0;
        run_expect(20, 8'h01, 4'd0, 1'b1, 1'b0, "note0");
        abc_tail();
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        RESET         = 1'b1;
        bus.START     = 1'b0;
        bus.STOP      = 1'b0;
        bus.LOAD_WE   = 1'b0;
        bus.LOAD_ADDR = '0;
        bus.LOAD_DATA = '0;
`ifdef MELODY_LOOP_EN
        bus.LOOP      = 1'b0;
`endif

        // Reset state, then a quiet idle period.
        #1;
        chk("reset", {bus.NOTE_SEL, bus.STEP_IDX, bus.BUSY, bus.DONE}, 14'h0000);
        step();
        step();
        RESET = 1'b0;
        run_expect(50, 8'h00, 4'd0, 1'b0, 1'b0, "idle50");

        // Basic three-entry melody.
        load(4'd0, 8'h02);
        load(4'd1, 8'h41);
        load(4'd2, 8'hF0);
        abc_full();

        // STOP five cycles into entry 0.
        bus.START = 1'b1;
        run_expect(1, 8'h00, 4'd0, 1'b1, 1'b0, "stop_fetch");
        bus.START = 1'b0;
        run_expect(5, 8'h01, 4'd0, 1'b1, 1'b0, "stop_note");
        bus.STOP = 1'b1;
        run_expect(1, 8'h00, 4'd0, 1'b0, 1'b0, "stop_abort");
        bus.STOP = 1'b0;
        run_expect(30, 8'h00, 4'd0, 1'b0, 1'b0, "stop_nodone");

        // START and STOP together from IDLE.
        bus.START = 1'b1;
        bus.STOP  = 1'b1;
        run_expect(1, 8'h00, 4'd0, 1'b0, 1'b0, "start_stop");
        bus.START = 1'b0;
        bus.STOP  = 1'b0;
        run_expect(3, 8'h00, 4'd0, 1'b0, 1'b0, "start_stop_idle");

        // LOAD_WE and START while BUSY are both ignored.
        bus.START = 1'b1;
        run_expect(1, 8'h00, 4'd0, 1'b1, 1'b0, "busy_fetch");
        bus.START     = 1'b0;
        bus.LOAD_WE   = 1'b1;
        bus.LOAD_ADDR = 4'd1;
        bus.LOAD_DATA = 8'h72;
        run_expect(1, 8'h01, 4'd0, 1'b1, 1'b0, "busy_write");
        bus.LOAD_WE = 1'b0;
        bus.START   = 1'b1;
        run_expect(1, 8'h01, 4'd0, 1'b1, 1'b0, "busy_start");
        bus.START = 1'b0;
        run_expect(18, 8'h01, 4'd0, 1'b1, 1'b0, "busy_note0");
        abc_tail();
        abc_full();

        // Asynchronous reset mid-note silences the output before the next edge.
        bus.START = 1'b1;
        run_expect(1, 8'h00, 4'd0, 1'b1, 1'b0, "arst_fetch");
        bus.START = 1'b0;
        run_expect(3, 8'h01, 4'd0, 1'b1, 1'b0, "arst_note");
        #3;
        RESET = 1'b1;
        #1;
        chk("arst_drop", {bus.NOTE_SEL, bus.STEP_IDX, bus.BUSY, bus.DONE}, 14'h0000);
        #1;
        RESET = 1'b0;
        run_expect(2, 8'h00, 4'd0, 1'b0, 1'b0, "arst_idle");
        // RAM survives reset.
        abc_full();

        // Rest with dur=0, then a melody with no END marker.
        load(4'd0, 8'h80);
        load(4'd1, 8'h31);
        for (int a = 2; a < 16; a++) begin
            load(4'(a), 8'h01);
        end
        bus.START = 1'b1;
        run_expect(1, 8'h00, 4'd0, 1'b1, 1'b0, "rest_fetch");
        bus.START = 1'b0;
        run_expect(10, 8'h00, 4'd0, 1'b1, 1'b0, "rest_play");
        run_expect(10, 8'h00, 4'd0, 1'b1, 1'b0, "rest_gap");
        run_expect(1,  8'h00, 4'd1, 1'b1, 1'b0, "f_fetch1");
        run_expect(10, 8'h08, 4'd1, 1'b1, 1'b0, "f_note1");
        run_expect(10, 8'h00, 4'd1, 1'b1, 1'b0, "f_gap1");
        for (int k = 2; k < 16; k++) begin
            run_expect(1,  8'h00, 4'(k), 1'b1, 1'b0, "full_fetch");
            run_expect(10, 8'h01, 4'(k), 1'b1, 1'b0, "full_note");
            run_expect(10, 8'h00, 4'(k), 1'b1, 1'b0, "full_gap");
        end
        run_expect(1, 8'h00, 4'd15, 1'b1, 1'b1, "eor_done");
        run_expect(2, 8'h00, 4'd15, 1'b0, 1'b0, "eor_idle");

`ifdef MELODY_LOOP_EN
        // LOOP=1 replays from entry 0 with no DONE; dropping LOOP ends at the next END.
        load(4'd0, 8'h02);
        load(4'd1, 8'h41);
        load(4'd2, 8'hF0);
        bus.LOOP  = 1'b1;
        bus.START = 1'b1;
        run_expect(1,  8'h00, 4'd0, 1'b1, 1'b0, "loop_fetch0");
        bus.START = 1'b0;
        run_expect(20, 8'h01, 4'd0, 1'b1, 1'b0, "loop_note0");
        run_expect(10, 8'h00, 4'd0, 1'b1, 1'b0, "loop_gap0");
        run_expect(1,  8'h00, 4'd1, 1'b1, 1'b0, "loop_fetch1");
        run_expect(10, 8'h10, 4'd1, 1'b1, 1'b0, "loop_note1");
        run_expect(10, 8'h00, 4'd1, 1'b1, 1'b0, "loop_gap1");
        run_expect(1,  8'h00, 4'd2, 1'b1, 1'b0, "loop_end");
        run_expect(1,  8'h00, 4'd0, 1'b1, 1'b0, "loop_refetch");
        bus.LOOP = 1'b0;
        run_expect(20, 8'h01, 4'd0, 1'b1, 1'b0, "loop_replay0");
        abc_tail();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
